// File: rtl/count_sched.sv
// Round-robin scheduler that shares one event counter among NUM_REQ requesters.
// Define COUNT_SCHED_TIMEOUT_EN to build the RUN-state watchdog and its abort pulse.
module count_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] target,
    input  logic                     event_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       abort
);
    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("count_sched: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   ptr, ptr_d, owner, owner_d, pick, owner_next;
    logic [PTR_W:0]     cand;
    logic               hit;
    logic               owner_req;
    logic [CNT_W-1:0]   tgt_q, tgt_d, count_d;
    logic [NUM_REQ-1:0] grant_d, done_d;

`ifdef COUNT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    wdog, wdog_d;
    logic [NUM_REQ-1:0] abort_d;
`endif

    assign owner_req  = req[owner];
    assign owner_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_REQ))
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            if (!hit && req[cand[PTR_W-1:0]]) begin
                hit  = 1'b1;
                pick = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        tgt_d   = tgt_q;
        count_d = count;
        done_d  = '0;
`ifdef COUNT_SCHED_TIMEOUT_EN
        wdog_d  = wdog;
        abort_d = '0;
`endif
        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_d = LOAD;
                    owner_d = pick;
                    tgt_d   = target[int'(pick) * CNT_W +: CNT_W];
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = owner_next;
                end else begin
                    state_d = RUN;
                    count_d = '0;
`ifdef COUNT_SCHED_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            RUN: begin
                // A dropped owner request cancels even on the completing cycle.
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = owner_next;
                end else if (count == tgt_q) begin
                    state_d       = DONE;
                    done_d[owner] = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    state_d        = DONE;
                    abort_d[owner] = 1'b1;
`endif
                end else begin
                    if (event_in)
                        count_d = count + 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
                    wdog_d = wdog + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = owner_next;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d != IDLE)
            grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            tgt_q <= '0;
            count <= '0;
            grant <= '0;
            busy  <= 1'b0;
            done  <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            owner <= owner_d;
            tgt_q <= tgt_d;
            count <= count_d;
            grant <= grant_d;
            busy  <= (state_d != IDLE);
            done  <= done_d;
        end
    end

`ifdef COUNT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog  <= '0;
            abort <= '0;
        end else begin
            wdog  <= wdog_d;
            abort <= abort_d;
        end
    end
`else
    assign abort = '0;
`endif

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus randomized runs against a
// round-robin reference model; the timeout scenario follows COUNT_SCHED_TIMEOUT_EN.
module tb_count_sched;
    localparam int NR  = 4;
    localparam int CW  = 8;
    localparam int TMO = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  target;
    logic              event_in;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [CW-1:0]     count;
    logic [NR-1:0]     done;
    logic [NR-1:0]     abort;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    count_sched #(.NUM_REQ(NR), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .target(target), .event_in(event_in),
        .grant(grant), .busy(busy), .count(count), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        event_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '1;
        target = '0;
        event_in = 1'b1;
        tick();
        tick();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (abort !== '0) begin errors++; $display("FAIL reset_abort: got %b expected 0000", abort); end
        req = '0;
        event_in = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: grant %b busy %b expected 0000/0", grant, busy); end
        m_ptr = 0;
    endtask

    task automatic test_single_run();
        int idx;
        req = 4'b0001;
        target[0 +: CW] = 8'd5;
        event_in = 1'b1;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx) || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got %b/%b expected %b/1", grant, busy, oh(idx)); end
        tick();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            checks++; if (count !== CW'(k) || done !== '0) begin errors++; $display("FAIL single_count: got %0d done %b expected %0d done 0000", count, done, k); end
        end
        tick();
        checks++; if (done !== oh(idx) || count !== 8'd5) begin errors++; $display("FAIL single_done: got %b count %0d expected %b count 5", done, count, oh(idx)); end
        tick();
        req = '0;
        checks++; if (done !== '0 || grant !== '0 || busy !== 1'b0 || count !== 8'd5) begin
            errors++; $display("FAIL single_idle: done %b grant %b busy %b count %0d expected 0000 0000 0 5", done, grant, busy, count);
        end
        m_ptr = (idx + 1) % NR;
    endtask

    task automatic test_round_robin();
        int idx, n;
        do_reset();
        req = '1;
        event_in = 1'b1;
        for (int i = 0; i < NR; i++) target[i*CW +: CW] = 8'd2;
        for (int g = 0; g < 5; g++) begin
            idx = pick(m_ptr, req);
            n = 0;
            do begin tick(); n++; end while (grant === '0 && n < 8);
            checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, grant, oh(idx)); end
            n = 0;
            do begin
                tick(); n++;
                checks++; if ($countones(grant) > 1) begin errors++; $display("FAIL rr_onehot: got %b expected at most one bit", grant); end
            end while (done === '0 && n < 10);
            checks++; if (done !== oh(idx) || count !== 8'd2) begin errors++; $display("FAIL rr_done%0d: got %b count %0d expected %b count 2", g, done, count, oh(idx)); end
            m_ptr = (idx + 1) % NR;
        end
        tick();
        req = '0;
    endtask

    task automatic test_zero_and_gaps();
        int idx, mcount, n;
        logic e;
        req = 4'b0100;
        target[2*CW +: CW] = 8'd0;
        event_in = 1'b0;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL zero_grant: got %b expected %b", grant, oh(idx)); end
        tick();
        tick();
        checks++; if (done !== oh(idx) || count !== '0) begin errors++; $display("FAIL zero_done: got %b count %0d expected %b count 0", done, count, oh(idx)); end
        tick();
        req = '0;
        m_ptr = (idx + 1) % NR;

        req = 4'b0100;
        target[2*CW +: CW] = 8'd3;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL gaps_grant: got %b expected %b", grant, oh(idx)); end
        tick();
        mcount = 0;
        e = 1'b1;
        n = 0;
        while (n < 20) begin
            checks++; if (count !== CW'(mcount) || done !== '0) begin errors++; $display("FAIL gaps_count: got %0d done %b expected %0d done 0000", count, done, mcount); end
            if (mcount == 3) begin
                event_in = 1'b1;
                tick();
                checks++; if (done !== oh(idx) || count !== 8'd3) begin errors++; $display("FAIL gaps_done: got %b count %0d expected %b count 3", done, count, oh(idx)); end
                break;
            end
            event_in = e;
            if (e) mcount++;
            e = ~e;
            tick();
            n++;
        end
        if (n >= 20) begin checks++; errors++; $display("FAIL gaps_timeout: got no done expected done within 20 cycles"); end
        tick();
        req = '0;
        event_in = 1'b0;
        m_ptr = (idx + 1) % NR;
    endtask

    task automatic test_cancel();
        int idx, n;
        do_reset();
        req = 4'b0010;
        target[1*CW +: CW] = 8'd7;
        target[2*CW +: CW] = 8'd1;
        event_in = 1'b1;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL cancel_grant: got %b expected %b", grant, oh(idx)); end
        tick();
        tick();
        tick();
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL cancel_pre: got %0d expected 2", count); end
        req = 4'b1101;
        tick();
        checks++; if (grant !== '0 || busy !== 1'b0 || done !== '0 || count !== 8'd2) begin
            errors++; $display("FAIL cancel_idle: grant %b busy %b done %b count %0d expected 0000 0 0000 2", grant, busy, done, count);
        end
        m_ptr = (idx + 1) % NR;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL cancel_next: got %b expected %b", grant, oh(idx)); end
        n = 0;
        do begin tick(); n++; end while (done === '0 && n < 10);
        checks++; if (done !== oh(idx)) begin errors++; $display("FAIL cancel_next_done: got %b expected %b", done, oh(idx)); end
        tick();
        req = '0;
        event_in = 1'b0;
        m_ptr = (idx + 1) % NR;
    endtask

    task automatic test_reset_mid_run();
        int idx, n;
        req = 4'b0001;
        target[0 +: CW] = 8'd9;
        target[1*CW +: CW] = 8'd0;
        event_in = 1'b1;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL midrst_grant: got %b expected %b", grant, oh(idx)); end
        tick();
        for (int k = 0; k < 4; k++) tick();
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL midrst_pre: got %0d expected 4", count); end
        reset = 1'b0;
        req = 4'b1010;
        #1;
        checks++; if (grant !== '0 || busy !== 1'b0 || count !== '0 || done !== '0 || abort !== '0) begin
            errors++; $display("FAIL midrst_async: grant %b busy %b count %0d done %b abort %b expected all 0", grant, busy, count, done, abort);
        end
        tick();
        reset = 1'b1;
        m_ptr = 0;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL midrst_regrant: got %b expected %b", grant, oh(idx)); end
        n = 0;
        do begin tick(); n++; end while (done === '0 && n < 10);
        checks++; if (done !== oh(idx)) begin errors++; $display("FAIL midrst_done: got %b expected %b", done, oh(idx)); end
        tick();
        req = '0;
        event_in = 1'b0;
        m_ptr = (idx + 1) % NR;
    endtask

    task automatic test_timeout();
        int idx;
        req = 4'b1000;
        target[3*CW +: CW] = 8'd50;
        event_in = 1'b0;
        idx = pick(m_ptr, req);
        tick();
        checks++; if (grant !== oh(idx)) begin errors++; $display("FAIL tmo_grant: got %b expected %b", grant, oh(idx)); end
        for (int k = 1; k <= TMO; k++) begin
            tick();
            checks++; if (abort !== '0 || done !== '0 || busy !== 1'b1) begin
                errors++; $display("FAIL tmo_run%0d: abort %b done %b busy %b expected 0000 0000 1", k, abort, done, busy);
            end
        end
`ifdef COUNT_SCHED_TIMEOUT_EN
        tick();
        checks++; if (abort !== oh(idx) || done !== '0) begin errors++; $display("FAIL tmo_abort: got %b done %b expected %b done 0000", abort, done, oh(idx)); end
        tick();
        req = '0;
        checks++; if (busy !== 1'b0 || abort !== '0) begin errors++; $display("FAIL tmo_idle: busy %b abort %b expected 0 0000", busy, abort); end
`else
        for (int k = 0; k < TMO; k++) begin
            tick();
            checks++; if (abort !== '0 || busy !== 1'b1 || done !== '0) begin
                errors++; $display("FAIL notmo_run: abort %b busy %b done %b expected 0000 1 0000", abort, busy, done);
            end
        end
        req = '0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notmo_cancel: busy %b expected 0", busy); end
`endif
        m_ptr = (idx + 1) % NR;
    endtask

    task automatic test_random();
        int idx, t, mcount, rc;
        logic finished, use_cancel, e;
        logic [NR-1:0] r;
        for (int ep = 0; ep < 40; ep++) begin
            r = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) target[i*CW +: CW] = CW'($urandom_range(0, 6));
            req = r;
            event_in = 1'($urandom);
            idx = pick(m_ptr, r);
            t = int'(target[idx*CW +: CW]);
            tick();
            checks++; if (grant !== oh(idx) || busy !== 1'b1) begin errors++; $display("FAIL rnd_grant%0d: got %b/%b expected %b/1", ep, grant, busy, oh(idx)); end
            for (int i = 0; i < NR; i++) target[i*CW +: CW] = CW'($urandom_range(0, 6));
            tick();
            mcount = 0;
            rc = 1;
            finished = 1'b0;
            use_cancel = ($urandom_range(0, 3) == 0);
            while (!finished && rc < 60) begin
                checks++; if (count !== CW'(mcount) || done !== '0 || abort !== '0 || grant !== oh(idx)) begin
                    errors++; $display("FAIL rnd_run%0d: count %0d done %b abort %b grant %b expected %0d 0000 0000 %b", ep, count, done, abort, grant, mcount, oh(idx));
                end
                e = ($urandom_range(0, 3) != 0);
                event_in = e;
                r = NR'($urandom) | oh(idx);
                if (use_cancel && $urandom_range(0, 7) == 0) begin
                    r[idx] = 1'b0;
                    req = r;
                    tick();
                    checks++; if (grant !== '0 || busy !== 1'b0 || done !== '0 || count !== CW'(mcount)) begin
                        errors++; $display("FAIL rnd_cancel%0d: grant %b busy %b done %b count %0d expected 0000 0 0000 %0d", ep, grant, busy, done, count, mcount);
                    end
                    req = '0;
                    finished = 1'b1;
                end else if (mcount == t) begin
                    req = r;
                    tick();
                    checks++; if (done !== oh(idx) || abort !== '0 || count !== CW'(t)) begin
                        errors++; $display("FAIL rnd_done%0d: done %b abort %b count %0d expected %b 0000 %0d", ep, done, abort, count, oh(idx), t);
                    end
                    tick();
                    req = '0;
                    checks++; if (grant !== '0 || busy !== 1'b0 || done !== '0) begin
                        errors++; $display("FAIL rnd_idle%0d: grant %b busy %b done %b expected 0000 0 0000", ep, grant, busy, done);
                    end
                    finished = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
                end else if (rc == TMO) begin
                    req = r;
                    tick();
                    checks++; if (abort !== oh(idx) || done !== '0) begin
                        errors++; $display("FAIL rnd_abort%0d: abort %b done %b expected %b 0000", ep, abort, done, oh(idx));
                    end
                    tick();
                    req = '0;
                    finished = 1'b1;
`endif
                end else begin
                    req = r;
                    if (e) mcount++;
                    tick();
                    rc++;
                end
            end
            if (!finished) begin
                checks++; errors++;
                $display("FAIL rnd_stuck%0d: got no completion expected one within 60 cycles", ep);
                do_reset();
            end else begin
                m_ptr = (idx + 1) % NR;
            end
        end
        event_in = 1'b0;
    endtask

    initial begin
        req = '0;
        target = '0;
        event_in = 1'b0;
        reset = 1'b0;
        test_reset();
        test_single_run();
        test_round_robin();
        test_zero_and_gaps();
        test_cancel();
        test_reset_mid_run();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
